// File: rtl/alu_arbiter.sv
// Round-robin front end for a shared combinational ALU. It latches one request,
// executes it for one cycle and holds the result until the owner acknowledges it.
module alu_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [2:0]       op0,
    input  logic [2:0]       op1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             rsp_valid0,
    output logic             rsp_valid1,
    input  logic             rsp_ack0,
    input  logic             rsp_ack1,
    output logic [WIDTH-1:0] rsp_result,
    output logic [3:0]       rsp_flags,
    output logic             busy,
    output logic [WIDTH-1:0] alu_operand1,
    output logic [WIDTH-1:0] alu_operand2,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry,
    input  logic             alu_overflow,
    input  logic             alu_negative,
    input  logic             alu_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic             prio_reg, prio_next;
    logic             sel_reg, sel_next;
    logic [2:0]       op_reg, op_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic [1:0]       gnt_reg, gnt_next;
    logic [1:0]       valid_reg, valid_next;
    logic             busy_reg, busy_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic [3:0]       flags_reg, flags_next;

    logic [1:0] req_vec;
    logic [1:0] ack_vec;
    logic [1:0] win;

    assign req_vec = {req1, req0};
    assign ack_vec = {rsp_ack1, rsp_ack0};

    // A requester wins if it asks alone, or if both ask and it holds priority.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_win
            assign win[gi] = req_vec[gi] & (~req_vec[1-gi] | (prio_reg == 1'(gi)));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio_reg   <= 1'b0;
            sel_reg    <= 1'b0;
            op_reg     <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            gnt_reg    <= '0;
            valid_reg  <= '0;
            busy_reg   <= 1'b0;
            result_reg <= '0;
            flags_reg  <= '0;
        end else begin
            prio_reg   <= prio_next;
            sel_reg    <= sel_next;
            op_reg     <= op_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            gnt_reg    <= gnt_next;
            valid_reg  <= valid_next;
            busy_reg   <= busy_next;
            result_reg <= result_next;
            flags_reg  <= flags_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        prio_next   = prio_reg;
        sel_next    = sel_reg;
        op_next     = op_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        gnt_next    = '0;
        valid_next  = valid_reg;
        result_next = result_reg;
        flags_next  = flags_reg;

        case (state_reg)
            IDLE: begin
                if (|req_vec) begin
                    sel_next   = win[1];
                    op_next    = win[1] ? op1 : op0;
                    a_next     = win[1] ? a1  : a0;
                    b_next     = win[1] ? b1  : b0;
                    gnt_next   = win;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                result_next         = alu_result;
                flags_next          = {alu_carry, alu_overflow, alu_negative, alu_zero};
                valid_next[sel_reg] = 1'b1;
                state_next          = RESP;
            end
            RESP: begin
                // Priority moves only when the owner consumes its response.
                if (ack_vec[sel_reg]) begin
                    valid_next[sel_reg] = 1'b0;
                    prio_next           = ~sel_reg;
                    state_next          = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    assign gnt0         = gnt_reg[0];
    assign gnt1         = gnt_reg[1];
    assign rsp_valid0   = valid_reg[0];
    assign rsp_valid1   = valid_reg[1];
    assign rsp_result   = result_reg;
    assign rsp_flags    = flags_reg;
    assign busy         = busy_reg;
    assign alu_op       = op_reg;
    assign alu_operand1 = a_reg;
    assign alu_operand2 = b_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized bench for alu_arbiter: a behavioural ALU sits on the alu_* ports and a
// transaction-level model predicts grant order, latency and captured results.
module tb_alu_arbiter;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [1:0]   req;
    logic [1:0]   ack;
    logic [2:0]   op [2];
    logic [W-1:0] a  [2];
    logic [W-1:0] b  [2];

    logic         gnt0, gnt1, rsp_valid0, rsp_valid1, busy;
    logic [W-1:0] rsp_result, alu_operand1, alu_operand2, alu_result;
    logic [3:0]   rsp_flags;
    logic [2:0]   alu_op;
    logic         alu_carry, alu_overflow, alu_negative, alu_zero;

    int checks = 0;
    int errors = 0;
    logic pending [2];
    logic model_prio;

    alu_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req[0]), .req1(req[1]),
        .op0(op[0]), .op1(op[1]),
        .a0(a[0]), .b0(b[0]), .a1(a[1]), .b1(b[1]),
        .gnt0(gnt0), .gnt1(gnt1),
        .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
        .rsp_ack0(ack[0]), .rsp_ack1(ack[1]),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .busy(busy),
        .alu_operand1(alu_operand1), .alu_operand2(alu_operand2), .alu_op(alu_op),
        .alu_result(alu_result),
        .alu_carry(alu_carry), .alu_overflow(alu_overflow),
        .alu_negative(alu_negative), .alu_zero(alu_zero)
    );

    // Returns {carry, overflow, negative, zero, result} from integer arithmetic.
    function automatic logic [W+3:0] alu_model(input logic [2:0] f,
                                               input logic [W-1:0] x, input logic [W-1:0] y);
        longint ux, uy, sx, sy, ru, rs, smax, smin;
        logic [W-1:0] r;
        logic c, v;
        ux = longint'(x);
        uy = longint'(y);
        sx = x[W-1] ? ux - (longint'(1) << W) : ux;
        sy = y[W-1] ? uy - (longint'(1) << W) : uy;
        smax = (longint'(1) << (W-1)) - 1;
        smin = -(longint'(1) << (W-1));
        c = 1'b0;
        v = 1'b0;
        r = '0;
        case (f)
            3'd0: begin
                ru = ux + uy; rs = sx + sy;
                r = ru[W-1:0]; c = (ru >= (longint'(1) << W)); v = (rs > smax) || (rs < smin);
            end
            3'd1: begin
                ru = ux - uy; rs = sx - sy;
                r = ru[W-1:0]; c = (ux >= uy); v = (rs > smax) || (rs < smin);
            end
            3'd2: r = x & y;
            3'd3: r = x | y;
            3'd4: r = x ^ y;
            3'd5: r = ~x;
            3'd6: r = x;
            default: return '0;
        endcase
        return {c, v, r[W-1], (r == '0), r};
    endfunction

    always_comb begin
        {alu_carry, alu_overflow, alu_negative, alu_zero, alu_result} =
            alu_model(alu_op, alu_operand1, alu_operand2);
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic [2:0] o, input logic [W-1:0] x,
                           input logic [W-1:0] y);
        op[r] = o;
        a[r] = x;
        b[r] = y;
        req[r] = 1'b1;
        pending[r] = 1'b1;
    endtask

    task automatic check_quiet(input string tag);
        check_val({tag, "_gnt"}, {30'd0, gnt1, gnt0}, 32'd0);
        check_val({tag, "_valid"}, {30'd0, rsp_valid1, rsp_valid0}, 32'd0);
        check_val({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    // One full handshake; at least one request must be pending and the DUT idle.
    task automatic run_txn(input int hold, output logic [W+3:0] res, output int sel);
        logic [1:0] onehot;
        logic [2:0] t_op;
        logic [W-1:0] t_a, t_b;
        sel = (pending[0] && pending[1]) ? int'(model_prio) : (pending[1] ? 1 : 0);
        onehot = 2'(1 << sel);
        t_op = op[sel];
        t_a = a[sel];
        t_b = b[sel];
        res = alu_model(t_op, t_a, t_b);
        ack = 2'($urandom_range(0, 3));
        tick();
        check_val("gnt", {30'd0, gnt1, gnt0}, {30'd0, onehot});
        check_val("busy_exec", {31'd0, busy}, 32'd1);
        check_val("valid_exec", {30'd0, rsp_valid1, rsp_valid0}, 32'd0);
        check_val("alu_op", {29'd0, alu_op}, {29'd0, t_op});
        check_val("alu_opnd1", {16'd0, alu_operand1}, {16'd0, t_a});
        check_val("alu_opnd2", {16'd0, alu_operand2}, {16'd0, t_b});
        req[sel] = 1'b0;
        pending[sel] = 1'b0;
        ack = 2'($urandom_range(0, 3));
        tick();
        for (int i = 0; i <= hold; i++) begin
            if (i > 0) begin
                ack = ($urandom_range(0, 1) != 0) ? ~onehot : 2'b00;
                tick();
            end
            check_val("valid_resp", {30'd0, rsp_valid1, rsp_valid0}, {30'd0, onehot});
            check_val("result", {16'd0, rsp_result}, {16'd0, res[W-1:0]});
            check_val("flags", {28'd0, rsp_flags}, {28'd0, res[W+3:W]});
            check_val("gnt_busy", {30'd0, gnt1, gnt0}, 32'd0);
        end
        ack = onehot | (($urandom_range(0, 1) != 0) ? ~onehot : 2'b00);
        tick();
        ack = 2'b00;
        check_quiet("done");
        model_prio = ~onehot[1];
        $display("txn sel=%0d op=%0d a=%h b=%h -> result=%h flags=%b hold=%0d",
                 sel, t_op, t_a, t_b, res[W-1:0], res[W+3:W], hold);
    endtask

    logic [W+3:0] res;
    int sel;

    initial begin
        rst_n = 1'b0;
        req = 2'b00;
        ack = 2'b00;
        for (int r = 0; r < 2; r++) begin
            op[r] = '0; a[r] = '0; b[r] = '0; pending[r] = 1'b0;
        end
        model_prio = 1'b0;
        tick();
        tick();
        check_quiet("reset");
        check_val("reset_result", {16'd0, rsp_result}, 32'd0);
        check_val("reset_flags", {28'd0, rsp_flags}, 32'd0);
        check_val("reset_alu", {alu_op, alu_operand1, alu_operand2} == '0 ? 32'd0 : 32'd1, 32'd0);
        rst_n = 1'b1;

        set_req(0, 3'd0, 16'h7FFF, 16'h0001);
        run_txn(5, res, sel);
        check_val("add_const", {12'd0, res}, {12'd0, 4'b0110, 16'h8000});
        set_req(1, 3'd1, 16'h0005, 16'h0005);
        run_txn(0, res, sel);
        check_val("sub_const", {12'd0, res}, {12'd0, 4'b1001, 16'h0000});
        set_req(1, 3'd5, 16'hFFFF, 16'hFFFF);
        run_txn(1, res, sel);
        check_val("not_const", {12'd0, res}, {12'd0, 4'b0001, 16'h0000});
        set_req(1, 3'd7, 16'h1234, 16'h00FF);
        run_txn(2, res, sel);
        check_val("op7_const", {12'd0, res}, 32'd0);

        // Reset while a response is waiting for its acknowledge.
        set_req(0, 3'd4, 16'hA5A5, 16'h0F0F);
        tick();
        req = 2'b00;
        pending[0] = 1'b0;
        tick();
        check_val("pre_reset_valid", {31'd0, rsp_valid0}, 32'd1);
        rst_n = 1'b0;
        tick();
        tick();
        check_quiet("midreset");
        check_val("midreset_result", {16'd0, rsp_result}, 32'd0);
        check_val("midreset_flags", {28'd0, rsp_flags}, 32'd0);
        rst_n = 1'b1;
        model_prio = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_quiet("post_reset");
        end

        for (int i = 0; i < 4; i++) begin
            for (int r = 0; r < 2; r++) begin
                if (!pending[r]) set_req(r, 3'($urandom_range(0, 7)), W'($urandom), W'($urandom));
            end
            run_txn(0, res, sel);
            check_val("rr_order", sel, i % 2);
        end
        req = 2'b00;
        pending[0] = 1'b0;
        pending[1] = 1'b0;

        for (int i = 0; i < 150; i++) begin
            for (int r = 0; r < 2; r++) begin
                if (!pending[r] && $urandom_range(0, 1) != 0)
                    set_req(r, 3'($urandom_range(0, 7)), W'($urandom), W'($urandom));
            end
            if (!pending[0] && !pending[1]) begin
                ack = 2'($urandom_range(0, 3));
                tick();
                ack = 2'b00;
                check_quiet("idle");
            end else begin
                run_txn($urandom_range(0, 3), res, sel);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Sequences access to the shared combinational ALU for two requesters, e.g. the main execute path and an auxiliary address/compare unit.
- Each request is latched on grant, then driven to the ALU for one execute cycle.
- The result and flags {carry, overflow, negative, zero} are captured and held until the requester acknowledges them.
- Round-robin arbitration prevents starvation; the ALU sits outside this block.

Parameters:
- WIDTH, 16, operand/result width; must match the ALU width parameter.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req0, req1  in  1 each  request from requester 0/1; held until the matching gnt pulse.
- op0, op1  in  3 each  ALU opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT, 110 PASS.
- a0, b0, a1, b1  in  WIDTH each  operand1/operand2 per requester.
- gnt0, gnt1  out  1 each  one-cycle pulse; the request was accepted and its operands latched.
- rsp_valid0, rsp_valid1  out  1 each  the response for that requester is held on rsp_result/rsp_flags.
- rsp_ack0, rsp_ack1  in  1 each  the requester consumes the response.
- rsp_result  out  WIDTH  captured ALU result.
- rsp_flags  out  4  captured {carry, overflow, negative, zero}, bits [3:0].
- busy  out  1  high in EXEC and RESP.
- alu_operand1, alu_operand2  out  WIDTH  to ALU, driven from the latched operands.
- alu_op  out  3  to ALU.
- alu_result  in  WIDTH  from ALU.
- alu_carry, alu_overflow, alu_negative, alu_zero  in  1 each  from ALU.

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-low. On a clk edge with rst_n=0:
  - state=IDLE, prio=0.
  - gnt*=0, rsp_valid*=0, busy=0.
  - rsp_result=0, rsp_flags=0.
  - Latched op/operands=0, so alu_* outputs=0.
- Reset mid-operation: any in-flight or unacknowledged response is discarded, with no grant or valid pulse afterwards.
- All outputs are registered, except alu_* which come straight from the latches.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Sampled at the edge: if neither req is high, stay in IDLE.
  - If exactly one req is high, select it. If both are high, select requester prio.
  - At that edge: latch the selected op/a/b, pulse gnt of the selected requester for the following cycle, record the selection in sel, go to EXEC.
- EXEC: lasts exactly one cycle.
  - alu_* carry the latched values.
  - At the edge: rsp_result<=alu_result, rsp_flags<={alu_carry, alu_overflow, alu_negative, alu_zero}, rsp_valid[sel]<=1, go to RESP.
- RESP:
  - rsp_valid[sel], rsp_result and rsp_flags are held stable.
  - When rsp_ack[sel]=1 at an edge: rsp_valid[sel]<=0, prio<=~sel, go to IDLE.
  - rsp_ack of the non-selected requester is ignored.
  - rsp_ack asserted outside RESP is ignored.
- Latency:
  - req sampled at edge N → gnt high in cycle N+1, rsp_valid high from cycle N+2.
  - If ack is high in cycle N+2, rsp_valid drops at N+3 and a new request can be sampled at edge N+3.
  - Best-case throughput is one operation per 3 cycles.
- Request sampling: req is sampled only in IDLE. A req that rises during EXEC or RESP waits; it is never lost while held.
- Simultaneous requests:
  - Both held continuously → grants alternate 0,1,0,1.
  - prio updates only on completion (ack), not on grant.
- Requester obligations: a requester must deassert req in the cycle its gnt is seen unless it wants another operation. A req still high in IDLE is a new request.
- Opcode 111 is passed to the ALU unchanged. The ALU returns result 0 and flags 0000, which are captured as-is; no error is raised.
- Width: no arithmetic in this block. Flags are copied bit-exact. rsp_flags reflects the ALU's signed-overflow and carry semantics (SUB carry=1 means no borrow).

Test Plan:
- Reset: rst_n=0 for 2 cycles during RESP with rsp_valid0=1 → next cycle all outputs 0, state IDLE, no gnt/valid pulse after release.
- Single ADD: req0, op0=000, a0=0x7FFF, b0=0x0001 → gnt0 at N+1, rsp_valid0 at N+2, rsp_result=0x8000, rsp_flags=0110; hold ack0=0 for 5 cycles → values stable; ack0=1 → rsp_valid0 drops next edge.
- SUB zero and NOT: requester 1 SUB 0x0005-0x0005 → rsp_result=0x0000, rsp_flags=1001. Then NOT b1=0xFFFF → rsp_result=0x0000, rsp_flags=0001.
- Contention: req0 and req1 both held high from reset, immediate acks → gnt order 0,1,0,1; no gnt while busy=1.
- Wrong ack: in RESP for sel=0, pulse ack1 → rsp_valid0 stays 1 and state is unchanged. Then ack0 → return to IDLE, prio=1.
- Opcode 111: op1=111, a1=0x1234, b1=0x00FF → rsp_result=0x0000, rsp_flags=0000, normal handshake.
